mcs4_bus_master: RTL and testbench

- Host-side bus initiator for the MCS-4 nibble bus. It is the counterpart of the i4001/i4002 responders.
- Generates clken_1/clken_2/sync and runs 8-subcycle instruction cycles (A1 A2 A3 M1 M2 X1 X2 X3) on request from a simple valid/ready port.
- Lets PYNQ-side logic or a bench fetch ROM bytes, issue SRC, and perform I/O reads/writes without an i4004.
- Drives the same OR-combined bus as the CPU and replaces it in responder-only configurations.

---
 rtl/mcs4_bus_master.sv | 210 +++++++++++++++++++++
 tb/tb_mcs4_bus_master.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mcs4_bus_master.sv
// MCS-4 nibble-bus initiator: free-running A1..X3 sequencer plus a one-entry
// request holding register that launches FETCH, SRC, WRR and RDR cycles.
module mcs4_bus_master #(
    parameter int          PHASE_CLKS  = 4,
    parameter logic [3:0]  CM_RAM_MASK = 4'b0001
) (
    input  logic        clk,
    input  logic        rst,
    output logic        clken_1,
    output logic        clken_2,
    output logic        sync,
    output logic        cm_rom,
    output logic [3:0]  cm_ram,
    input  logic [3:0]  dbus_in,
    output logic [3:0]  dbus_out,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [11:0] req_addr,
    input  logic [3:0]  req_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data
);

    localparam int PW = $clog2(PHASE_CLKS);
    localparam logic [PW-1:0] PH_LAST = PW'(PHASE_CLKS - 1);
    localparam logic [PW-1:0] PH_MID  = PW'(PHASE_CLKS / 2);

    localparam logic [2:0] S_A1 = 3'd0;
    localparam logic [2:0] S_A2 = 3'd1;
    localparam logic [2:0] S_A3 = 3'd2;
    localparam logic [2:0] S_M1 = 3'd3;
    localparam logic [2:0] S_M2 = 3'd4;
    localparam logic [2:0] S_X2 = 3'd6;
    localparam logic [2:0] S_X3 = 3'd7;

    localparam logic [1:0] OP_FETCH = 2'b00;
    localparam logic [1:0] OP_SRC   = 2'b01;
    localparam logic [1:0] OP_IOWR  = 2'b10;
    localparam logic [1:0] OP_IORD  = 2'b11;

    // r_sub/r_ph name the position of the cycle about to start
    logic [2:0]    r_sub;
    logic [PW-1:0] r_ph;
    logic [2:0]    r_cur_sub;

    logic          r_pend;
    logic [1:0]    r_pop;
    logic [11:0]   r_paddr;
    logic [3:0]    r_pdata;

    logic          r_act;
    logic [1:0]    r_aop;
    logic [11:0]   r_aaddr;
    logic [3:0]    r_adata;
    logic [3:0]    r_opr;

    logic          r_clken_1;
    logic          r_clken_2;
    logic          r_sync;
    logic          r_cm_rom;
    logic [3:0]    r_cm_ram;
    logic [3:0]    r_dbus;
    logic          r_ready;
    logic          r_rsp_valid;
    logic [7:0]    r_rsp_data;

    logic          w_launch;
    logic          w_accept;
    logic          w_pend_next;
    logic          w_act;
    logic [1:0]    w_op;
    logic [11:0]   w_addr;
    logic [3:0]    w_data;
    logic [11:0]   w_bus_addr;
    logic          w_is_io;
    logic [3:0]    w_dbus;
    logic          w_cm_rom;
    logic [3:0]    w_cm_ram;

    assign w_launch    = (r_sub == S_A1) && (r_ph == '0);
    assign w_accept    = req_valid && r_ready;
    assign w_pend_next = w_accept || (r_pend && !w_launch);

    assign w_act  = w_launch ? r_pend  : r_act;
    assign w_op   = w_launch ? r_pop   : r_aop;
    assign w_addr = w_launch ? r_paddr : r_aaddr;
    assign w_data = w_launch ? r_pdata : r_adata;

    assign w_bus_addr = (w_op == OP_FETCH) ? w_addr : 12'h000;
    assign w_is_io    = (w_op == OP_IOWR) || (w_op == OP_IORD);

    always_comb begin
        w_dbus   = 4'h0;
        w_cm_rom = 1'b0;
        w_cm_ram = 4'h0;
        if (w_act) begin
            case (r_sub)
                S_A1: w_dbus = w_bus_addr[3:0];
                S_A2: w_dbus = w_bus_addr[7:4];
                S_A3: begin
                    w_dbus   = w_bus_addr[11:8];
                    w_cm_rom = 1'b1;
                end
                S_M1: if (w_is_io) w_dbus = 4'hE;
                S_M2: if (w_is_io) begin
                    w_dbus   = (w_op == OP_IOWR) ? 4'h2 : 4'hA;
                    w_cm_rom = 1'b1;
                    w_cm_ram = CM_RAM_MASK;
                end
                S_X2: begin
                    if (w_op == OP_SRC) begin
                        w_dbus   = w_addr[7:4];
                        w_cm_rom = 1'b1;
                        w_cm_ram = CM_RAM_MASK;
                    end else if (w_op == OP_IOWR) begin
                        w_dbus = w_data;
                    end
                end
                S_X3: if (w_op == OP_SRC) w_dbus = w_addr[3:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sub       <= S_X3;
            r_ph        <= '0;
            r_cur_sub   <= S_X3;
            r_pend      <= 1'b0;
            r_pop       <= OP_FETCH;
            r_paddr     <= 12'h000;
            r_pdata     <= 4'h0;
            r_act       <= 1'b0;
            r_aop       <= OP_FETCH;
            r_aaddr     <= 12'h000;
            r_adata     <= 4'h0;
            r_opr       <= 4'h0;
            r_clken_1   <= 1'b0;
            r_clken_2   <= 1'b0;
            r_sync      <= 1'b0;
            r_cm_rom    <= 1'b0;
            r_cm_ram    <= 4'h0;
            r_dbus      <= 4'h0;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'h00;
        end else begin
            r_ph      <= (r_ph == PH_LAST) ? '0 : r_ph + PW'(1);
            r_sub     <= (r_ph == PH_LAST) ? r_sub + 3'd1 : r_sub;
            r_cur_sub <= r_sub;
            r_clken_1 <= (r_ph == '0);
            r_clken_2 <= (r_ph == PH_MID);

            if (r_ph == '0) begin
                r_sync   <= (r_sub == S_X3);
                r_dbus   <= w_dbus;
                r_cm_rom <= w_cm_rom;
                r_cm_ram <= w_cm_ram;
            end

            if (w_accept) begin
                r_pop   <= req_op;
                r_paddr <= req_addr;
                r_pdata <= req_data;
            end
            r_pend  <= w_pend_next;
            r_ready <= !w_pend_next;

            if (w_launch) begin
                r_act   <= r_pend;
                r_aop   <= r_pop;
                r_aaddr <= r_paddr;
                r_adata <= r_pdata;
            end

            // r_clken_2 marks the current clk as mid-subcycle: sample there
            r_rsp_valid <= 1'b0;
            if (r_act && r_clken_2) begin
                if (r_cur_sub == S_M1 && r_aop == OP_FETCH)
                    r_opr <= dbus_in;
                if (r_cur_sub == S_M2 && r_aop == OP_FETCH) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= {r_opr, dbus_in};
                end
                if (r_cur_sub == S_X2 && r_aop == OP_IORD) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= {4'h0, dbus_in};
                end
            end
            if (r_act && r_sub == S_X3 && r_ph == PH_LAST &&
                (r_aop == OP_SRC || r_aop == OP_IOWR)) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= 8'h00;
            end
        end
    end

    assign clken_1   = r_clken_1;
    assign clken_2   = r_clken_2;
    assign sync      = r_sync;
    assign cm_rom    = r_cm_rom;
    assign cm_ram    = r_cm_ram;
    assign dbus_out  = r_dbus;
    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_mcs4_bus_master.sv
// Directed bench for mcs4_bus_master: vector table of single ops plus
// idle, back-to-back and mid-cycle reset sequences.
module tb_mcs4_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        clken_1, clken_2, sync, cm_rom;
    logic [3:0]  cm_ram, dbus_in, dbus_out;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [11:0] req_addr;
    logic [3:0]  req_data;
    logic        rsp_valid;
    logic [7:0]  rsp_data;

    mcs4_bus_master #(.PHASE_CLKS(4), .CM_RAM_MASK(4'b0001)) dut (
        .clk(clk), .rst(rst),
        .clken_1(clken_1), .clken_2(clken_2), .sync(sync),
        .cm_rom(cm_rom), .cm_ram(cm_ram),
        .dbus_in(dbus_in), .dbus_out(dbus_out),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    // Responder side of the bus: tracks the subcycle from sync/clken_1
    logic [2:0] tb_sub = 3'd7;
    logic [3:0] ext_opr = 4'h0, ext_opa = 4'h0, ext_io = 4'h0;
    logic [3:0] ext;
    always @(posedge clk) if (clken_1) tb_sub <= sync ? 3'd7 : tb_sub + 3'd1;
    always_comb begin
        ext = 4'h0;
        case (tb_sub)
            3'd3: ext = ext_opr;
            3'd4: ext = ext_opa;
            3'd6: ext = ext_io;
            default: ;
        endcase
    end
    assign dbus_in = dbus_out | ext;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic wait_ready(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (req_ready) break;
            @(negedge clk);
        end
        chk("ready_wait", {31'd0, req_ready}, 32'd1);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [3:0]  data;
        logic [3:0]  opr, opa, io;
        logic [31:0] e_dbus;
        logic [7:0]  e_rom;
        logic [31:0] e_ram;
        int          e_k;
        logic [7:0]  e_rsp;
    } vec_t;

    vec_t vt[7];

    task automatic run_vec(input int i);
        logic [31:0] g_dbus, g_ram;
        logic [7:0]  g_rom, g_sync, g_rsp;
        int          g_k, g_n;
        g_dbus = '0; g_ram = '0; g_rom = '0; g_sync = '0;
        g_rsp = '0; g_k = -1; g_n = 0;
        ext_opr = vt[i].opr; ext_opa = vt[i].opa; ext_io = vt[i].io;
        wait_ready(100);
        req_valid = 1'b1;
        req_op = vt[i].op; req_addr = vt[i].addr; req_data = vt[i].data;
        @(negedge clk);
        req_valid = 1'b0;
        chk($sformatf("v%0d_ready_drop", i), {31'd0, req_ready}, 32'd0);
        for (int w = 0; w < 80; w++) begin
            if (req_ready) break;
            @(negedge clk);
        end
        chk($sformatf("v%0d_launch", i), {30'd0, req_ready, clken_1, sync},
            32'b110);
        for (int k = 0; k < 32; k++) begin
            if (k % 4 == 1) begin
                g_dbus[4*(k/4) +: 4] = dbus_out;
                g_ram[4*(k/4) +: 4]  = cm_ram;
                g_rom[k/4]           = cm_rom;
                g_sync[k/4]          = sync;
            end
            if (rsp_valid) begin
                g_n++; g_k = k; g_rsp = rsp_data;
            end
            @(negedge clk);
        end
        chk($sformatf("v%0d_dbus", i), g_dbus, vt[i].e_dbus);
        chk($sformatf("v%0d_cm_rom", i), {24'd0, g_rom}, {24'd0, vt[i].e_rom});
        chk($sformatf("v%0d_cm_ram", i), g_ram, vt[i].e_ram);
        chk($sformatf("v%0d_sync", i), {24'd0, g_sync}, 32'h80);
        chk($sformatf("v%0d_rsp_cnt", i), 32'(g_n), 32'd1);
        chk($sformatf("v%0d_rsp_clk", i), 32'(g_k), 32'(vt[i].e_k));
        chk($sformatf("v%0d_rsp_data", i), {24'd0, g_rsp}, {24'd0, vt[i].e_rsp});
        ext_opr = 4'h0; ext_opa = 4'h0; ext_io = 4'h0;
    endtask

    initial begin
        int e1, e2, esy, ebus, n_rsp, n_acc, bad_data, t[3];
        logic acc;

        vt[0] = '{2'b00, 12'h123, 4'h0, 4'hA, 4'h5, 4'h0,
                  32'h0000_0123, 8'b0000_0100, 32'h0, 19, 8'hA5};
        vt[1] = '{2'b01, 12'h047, 4'h0, 4'h0, 4'h0, 4'h0,
                  32'h7400_0000, 8'b0100_0100, 32'h0100_0000, 31, 8'h00};
        vt[2] = '{2'b10, 12'hFFF, 4'h9, 4'h0, 4'h0, 4'h0,
                  32'h0902_E000, 8'b0001_0100, 32'h0001_0000, 31, 8'h00};
        vt[3] = '{2'b01, 12'h000, 4'h0, 4'h0, 4'h0, 4'h0,
                  32'h0000_0000, 8'b0100_0100, 32'h0100_0000, 31, 8'h00};
        vt[4] = '{2'b11, 12'h000, 4'h0, 4'h0, 4'h0, 4'hC,
                  32'h000A_E000, 8'b0001_0100, 32'h0001_0000, 27, 8'h0C};
        vt[5] = '{2'b01, 12'hF9A, 4'h0, 4'h0, 4'h0, 4'h0,
                  32'hA900_0000, 8'b0100_0100, 32'h0100_0000, 31, 8'h00};
        vt[6] = '{2'b00, 12'hFED, 4'h0, 4'h3, 4'hC, 4'h0,
                  32'h0000_0FED, 8'b0000_0100, 32'h0, 19, 8'h3C};

        rst = 1'b1; req_valid = 1'b0; req_op = 2'b00;
        req_addr = 12'h000; req_data = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs",
            {17'd0, clken_1, clken_2, sync, cm_rom, cm_ram, dbus_out, rsp_valid, rsp_data[3:0]},
            32'd0);
        chk("reset_rsp_data", {24'd0, rsp_data}, 32'd0);
        chk("reset_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b0;

        // Idle sequencing, clk 0 is the first clk after reset
        e1 = 0; e2 = 0; esy = 0; ebus = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (clken_1 !== (k % 4 == 0)) e1++;
            if (clken_2 !== (k % 4 == 2)) e2++;
            if (sync !== (k < 4 || (k >= 32 && k < 36))) esy++;
            if (dbus_out !== 4'h0 || cm_rom !== 1'b0 || cm_ram !== 4'h0 ||
                rsp_valid !== 1'b0 || req_ready !== 1'b1) ebus++;
        end
        chk("idle_clken_1", 32'(e1), 32'd0);
        chk("idle_clken_2", 32'(e2), 32'd0);
        chk("idle_sync", 32'(esy), 32'd0);
        chk("idle_bus", 32'(ebus), 32'd0);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Back-to-back FETCHes with req_valid held high
        ext_opr = 4'h6; ext_opa = 4'h9;
        n_rsp = 0; n_acc = 0; bad_data = 0;
        req_op = 2'b00; req_addr = 12'h100; req_valid = 1'b1;
        acc = req_ready;
        for (int k = 0; k < 160; k++) begin
            @(negedge clk);
            if (acc) begin
                n_acc++;
                if (n_acc == 3) req_valid = 1'b0;
                else req_addr = req_addr + 12'h001;
            end
            if (rsp_valid) begin
                if (n_rsp < 3) t[n_rsp] = k;
                n_rsp++;
                if (rsp_data !== 8'h69) bad_data++;
            end
            acc = req_valid && req_ready;
        end
        chk("b2b_accepts", 32'(n_acc), 32'd3);
        chk("b2b_rsp_cnt", 32'(n_rsp), 32'd3);
        chk("b2b_gap01", 32'(t[1] - t[0]), 32'd32);
        chk("b2b_gap12", 32'(t[2] - t[1]), 32'd32);
        chk("b2b_data", 32'(bad_data), 32'd0);

        // Reset during M1 of a FETCH with a second request pending
        wait_ready(100);
        req_valid = 1'b1; req_op = 2'b00; req_addr = 12'h3C5;
        @(negedge clk);
        req_valid = 1'b0;
        for (int w = 0; w < 80; w++) begin
            if (req_ready) break;
            @(negedge clk);
        end
        req_valid = 1'b1; req_addr = 12'h0AA;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_outs",
            {21'd0, clken_1, clken_2, sync, cm_rom, cm_ram, dbus_out, rsp_valid},
            32'd0);
        chk("midrst_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_first_x3", {30'd0, sync, clken_1}, 32'b11);
        n_rsp = 0;
        for (int k = 0; k < 40; k++) begin
            if (rsp_valid) n_rsp++;
            @(negedge clk);
        end
        chk("midrst_no_rsp", 32'(n_rsp), 32'd0);
        ext_opr = 4'h0; ext_opa = 4'h0;
        run_vec(0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
